// File: rtl/mem_interface_if.sv
// Datapath/RAM signal bundle for mem_interface; the slave modport is the
// controller's view, the master modport the surrounding datapath/RAM side.
interface mem_interface_if;
    logic [31:0] busMuxOut;
    logic        MARin;
    logic        MDRin;
    logic        Read;
    logic        Write;
    logic [31:0] busMuxInMDR;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        mem_busy;
    logic        mem_done;
    logic        mem_err;

    modport slave (
        input  busMuxOut, MARin, MDRin, Read, Write, mem_rdata, mem_ack,
        output busMuxInMDR, mem_addr, mem_wdata, mem_req, mem_we,
               mem_busy, mem_done, mem_err
    );

    modport master (
        output busMuxOut, MARin, MDRin, Read, Write, mem_rdata, mem_ack,
        input  busMuxInMDR, mem_addr, mem_wdata, mem_req, mem_we,
               mem_busy, mem_done, mem_err
    );
endinterface

// File: rtl/mem_interface.sv
// MAR/MDR register pair with a single-outstanding RAM request FSM,
// acknowledge/timeout completion and a one-cycle DONE status pulse.
module mem_interface #(
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              clear,
    mem_interface_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, RD_REQ, WR_REQ, DONE} state_e;

    localparam logic [4:0] TO_LAST = 5'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [8:0]  mar_q, mar_d;
    logic [31:0] mdr_q, mdr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                // Keeping the counter at zero here clears it on request entry.
                cnt_d = '0;
                err_d = 1'b0;
                if (bus.MARin) mar_d = bus.busMuxOut[8:0];
                if (bus.MDRin) mdr_d = bus.busMuxOut;
                if (bus.Read)       state_d = RD_REQ;
                else if (bus.Write) state_d = WR_REQ;
            end
            RD_REQ, WR_REQ: begin
                // Ack is tested first so it wins over a same-cycle timeout.
                if (bus.mem_ack) begin
                    state_d = DONE;
                    if (state_q == RD_REQ) mdr_d = bus.mem_rdata;
                end else if (cnt_q == TO_LAST) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_addr    = mar_q;
    assign bus.mem_wdata   = mdr_q;
    assign bus.busMuxInMDR = mdr_q;
    assign bus.mem_req     = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign bus.mem_we      = (state_q == WR_REQ);
    assign bus.mem_busy    = (state_q != IDLE);
    assign bus.mem_done    = (state_q == DONE);
    assign bus.mem_err     = (state_q == DONE) && err_q;
endmodule

// File: doc/mem_interface.md
MEM_INTERFACE -- requirements
Module: mem_interface

Interface
REQ-001 SHALL have port clock, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port clear, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port busMuxOut, input, 32 bits: datapath bus value, source for MAR/MDR loads.
REQ-004 SHALL have ports MARin and MDRin, input, 1 bit each: load MAR / MDR from busMuxOut.
REQ-005 SHALL have ports Read and Write, input, 1 bit each: transaction start requests, sampled in IDLE only.
REQ-006 SHALL have port busMuxInMDR, output, 32 bits: current MDR contents, fed to the datapath bus mux.
REQ-007 SHALL have ports mem_addr (output, 9 bits), mem_wdata (output, 32 bits), mem_req (output, 1 bit), mem_we (output, 1 bit): RAM request side.
REQ-008 SHALL have ports mem_rdata (input, 32 bits) and mem_ack (input, 1 bit): RAM response side.
REQ-009 SHALL have outputs mem_busy, mem_done and mem_err, 1 bit each: status to the control unit.
REQ-010 SHALL have parameter TIMEOUT, default 16, meaning: maximum request cycles before abort.

Function
REQ-011 SHALL hold a 9-bit MAR; with MARin=1 in IDLE, MAR <= busMuxOut[8:0] at the clock edge.
REQ-012 SHALL hold a 32-bit MDR; with MDRin=1 in IDLE, MDR <= busMuxOut at the clock edge.
REQ-013 SHALL ignore MARin and MDRin in every state other than IDLE, so address and write data stay stable.
REQ-014 SHALL drive mem_addr=MAR, mem_wdata=MDR and busMuxInMDR=MDR continuously.
REQ-015 SHALL implement the FSM states IDLE, RD_REQ, WR_REQ and DONE.
REQ-016 SHALL move from IDLE to RD_REQ on Read=1; otherwise from IDLE to WR_REQ on Write=1; Read has priority when both are 1, and the Write is dropped.
REQ-017 SHALL, in RD_REQ, drive mem_req=1 and mem_we=0; in WR_REQ, drive mem_req=1 and mem_we=1; in all other states both SHALL be 0.
REQ-018 SHALL, on mem_ack=1 in RD_REQ, load MDR <= mem_rdata and go to DONE.
REQ-019 SHALL, on mem_ack=1 in WR_REQ, go to DONE with MDR unchanged.
REQ-020 SHALL run a 5-bit wait counter, cleared on entry to RD_REQ/WR_REQ and incremented each request cycle without ack.
REQ-021 SHALL, on the TIMEOUT-th consecutive request cycle without ack, go to DONE with MDR unchanged and set a sticky error flag.
REQ-022 SHALL let ack win when ack and timeout occur in the same cycle: normal completion, no error.
REQ-023 SHALL spend exactly one cycle in DONE: mem_done=1, mem_err=error flag; then go to IDLE and clear the error flag.
REQ-024 SHALL drive mem_busy=1 in every state except IDLE.
REQ-025 SHALL ignore Read and Write outside IDLE, with no queuing.
REQ-026 SHALL ignore mem_ack in IDLE and DONE.
REQ-027 SHALL meet this latency: Read sampled at edge k gives mem_req=1 in cycle k+1; ack in that cycle gives MDR valid and mem_done=1 in cycle k+2, and IDLE in cycle k+3.
REQ-028 SHALL let MDRin and Read asserted together in IDLE load the bus value first; the read data then overwrites MDR on ack.

Reset
REQ-029 SHALL, while clear=0, immediately force state IDLE, MAR=0, MDR=0, counter=0 and error flag=0.
REQ-030 SHALL, while clear=0, drive all outputs to 0 (mem_addr=0, mem_wdata=0, busMuxInMDR=0).
REQ-031 SHALL treat clear=0 during RD_REQ/WR_REQ as an abort: mem_req drops asynchronously, with no mem_done and no MDR update.

Verification
REQ-032 SHALL verify read: MARin with bus=0x00000155, then Read; RAM acks after 2 cycles with 0xDEADBEEF -> mem_addr=0x155, mem_we=0, busMuxInMDR=0xDEADBEEF, one-cycle mem_done=1, mem_err=0.
REQ-033 SHALL verify write: MAR=0x010, MDRin with bus=0x12345678, then Write; ack after 1 cycle -> mem_we=1, mem_wdata=0x12345678 while mem_req=1, MDR unchanged, mem_done=1.
REQ-034 SHALL verify timeout: Read with ack never asserted -> mem_req high exactly 16 cycles, then mem_done=1 and mem_err=1 for one cycle, MDR unchanged, then IDLE.
REQ-035 SHALL verify boundaries: Read and Write together -> only a read (mem_we=0); MARin=1 with bus=0x0FF while busy -> MAR unchanged; ack on the 16th cycle -> mem_err=0.
REQ-036 SHALL verify reset mid-read: clear=0 during RD_REQ -> mem_req=0 with no clock edge, MDR=0, no mem_done; after release, a new Read completes normally.
REQ-037 SHALL verify address wrap: bus=0xFFFFFE00 on MARin -> mem_addr=0x000; bus=0x000003FF -> mem_addr=0x1FF.
